// File: rtl/demux1_29_seq_if.sv
// Bus bundle for the 1:29 registered demultiplexer: serial input side and
// parallel frame output side.
interface demux1_29_seq_if #(
    parameter int N     = 29,
    parameter int SEL_W = 5
);
    logic             din;
    logic             din_valid;
    logic [SEL_W-1:0] sel;
    logic             auto_mode;
    logic             start;
    logic [N-1:0]     outp;
    logic             frame_valid;
    logic             busy;
    logic             sel_err;
    logic             parity_err;

    modport master (
        output din, din_valid, sel, auto_mode, start,
        input  outp, frame_valid, busy, sel_err, parity_err
    );

    modport slave (
        input  din, din_valid, sel, auto_mode, start,
        output outp, frame_valid, busy, sel_err, parity_err
    );
endinterface

// File: rtl/demux1_29_seq.sv
// Registered 1:29 demultiplexer with an auto-incrementing frame sequencer.
// Define DEMUX_PARITY_EN to add a trailing even-parity bit check per frame.
module demux1_29_seq #(
    parameter int N     = 29,
    parameter int SEL_W = 5
) (
    input logic            clk,
    input logic            rst,
    demux1_29_seq_if.slave bus
);

`ifdef DEMUX_PARITY_EN
    typedef enum logic [1:0] {IDLE, FILL, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     outp_q, outp_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             fv_q, fv_d;
    logic             se_q, se_d;
`ifdef DEMUX_PARITY_EN
    logic             pe_q, pe_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            outp_q  <= '0;
            idx_q   <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            outp_q  <= outp_d;
            idx_q   <= idx_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
`ifdef DEMUX_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        outp_d  = outp_q;
        idx_d   = idx_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
`ifdef DEMUX_PARITY_EN
        pe_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.auto_mode) begin
                    if (bus.din_valid) begin
                        if (int'(bus.sel) < N) outp_d[bus.sel] = bus.din;
                        else                   se_d = 1'b1;
                    end
                end else if (bus.start) begin
                    // start outranks a coincident din_valid: that bit is dropped
                    outp_d  = '0;
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!bus.auto_mode) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    outp_d[idx_q] = bus.din;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef DEMUX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        fv_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef DEMUX_PARITY_EN
            PARITY: begin
                if (!bus.auto_mode) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    // even parity: the trailing bit must equal the XOR of the frame
                    pe_d    = (bus.din != ^outp_q);
                    fv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.outp        = outp_q;
    assign bus.frame_valid = fv_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.sel_err     = se_q;
`ifdef DEMUX_PARITY_EN
    assign bus.parity_err  = pe_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_29_seq.sv
// Directed testbench for demux1_29_seq: reset, direct mode, auto frames,
// start collisions, abort and (when DEMUX_PARITY_EN is defined) parity.
module tb_demux1_29_seq;

    localparam int N     = 29;
    localparam int SEL_W = 5;
`ifdef DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [N-1:0] PAT = 29'b11100011100011100011100011100;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    demux1_29_seq_if #(.N(N), .SEL_W(SEL_W)) bus ();

    demux1_29_seq #(.N(N), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        bus.sel       = '0;
    endtask

    // Start a frame and push all N bits; optional stalls between bits.
    task automatic send_frame(input logic [N-1:0] pat, input bit gaps);
        bus.auto_mode = 1'b1;
        bus.start     = 1'b1;
        tick();
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_clear", 32'(bus.outp), 32'd0);
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gaps && (i % 4 == 1)) begin
                bus.din_valid = 1'b0;
                bus.din       = ~pat[i];
                tick();
                chk("gap_fv", 32'(bus.frame_valid), 32'd0);
                chk("gap_busy", 32'(bus.busy), 32'd1);
            end
            bus.din       = pat[i];
            bus.din_valid = 1'b1;
            tick();
            chk("fill_fv", 32'(bus.frame_valid), 32'((i == N - 1) && !PAR));
            chk("fill_busy", 32'(bus.busy), 32'((i != N - 1) || PAR));
        end
        bus.din_valid = 1'b0;
        chk("frame_outp", 32'(bus.outp), 32'(pat));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.auto_mode = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_outp", 32'(bus.outp), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("rst_se", 32'(bus.sel_err), 32'd0);
        chk("rst_pe", 32'(bus.parity_err), 32'd0);
        rst = 1'b0;

        // Reset in the middle of an auto frame
        bus.auto_mode = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.din       = 1'b1;
            bus.din_valid = 1'b1;
            tick();
            chk("mid_fv", 32'(bus.frame_valid), 32'd0);
        end
        chk("mid_outp", 32'(bus.outp), 32'h3FF);
        bus.din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outp", 32'(bus.outp), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        send_frame(29'h0AAAAAAA, 1'b0);
        if (PAR) begin
            bus.din       = 1'b0;
            bus.din_valid = 1'b1;
            tick();
            chk("clean_par_fv", 32'(bus.frame_valid), 32'd1);
        end
        bus.din_valid = 1'b0;
        tick();
        chk("clean_fv_drop", 32'(bus.frame_valid), 32'd0);

        // Direct mode from a cleared register
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.auto_mode = 1'b0;
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        bus.sel = 5'd0;  tick(); chk("dir0_se", 32'(bus.sel_err), 32'd0);
        bus.sel = 5'd14; tick(); chk("dir14_se", 32'(bus.sel_err), 32'd0);
        bus.sel = 5'd28; tick(); chk("dir28_se", 32'(bus.sel_err), 32'd0);
        chk("dir_outp", 32'(bus.outp), 32'h10004001);
        bus.sel = 5'd29; tick();
        chk("bad_sel_se", 32'(bus.sel_err), 32'd1);
        chk("bad_sel_outp", 32'(bus.outp), 32'h10004001);
        bus.din_valid = 1'b0;
        tick();
        chk("bad_sel_pulse", 32'(bus.sel_err), 32'd0);
        bus.start = 1'b1;
        tick();
        chk("dir_start_ign", 32'(bus.busy), 32'd0);
        idle_inputs();

        // Auto frame with stalls; din_valid in IDLE auto mode ignored first
        bus.auto_mode = 1'b1;
        bus.sel       = 5'd3;
        bus.din       = 1'b0;
        bus.din_valid = 1'b1;
        tick();
        chk("auto_idle_ign", 32'(bus.outp), 32'h10004001);
        bus.din_valid = 1'b0;
        send_frame(PAT, 1'b1);
        if (PAR) begin
            bus.din       = ^PAT;
            bus.din_valid = 1'b1;
            tick();
            chk("pat_par_fv", 32'(bus.frame_valid), 32'd1);
            chk("pat_par_pe", 32'(bus.parity_err), 32'd0);
            bus.din_valid = 1'b0;
        end
        tick();
        chk("pat_fv_drop", 32'(bus.frame_valid), 32'd0);
        chk("pat_hold", 32'(bus.outp), 32'(PAT));

        // Start and data in the same cycle, then a second start mid-frame
        bus.start     = 1'b1;
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        tick();
        chk("coll_outp", 32'(bus.outp), 32'd0);
        bus.start = 1'b0;
        bus.din   = 1'b0;
        tick();
        chk("coll_bit0", 32'(bus.outp), 32'd0);
        bus.din = 1'b1;
        tick();
        chk("coll_bit1", 32'(bus.outp), 32'd2);
        bus.din_valid = 1'b0;
        bus.start     = 1'b1;
        tick();
        chk("restart_ign_outp", 32'(bus.outp), 32'd2);
        chk("restart_ign_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.din_valid = 1'b1;
        tick();
        chk("restart_idx", 32'(bus.outp), 32'd6);
        bus.din_valid = 1'b0;

        // Abort after five ones
        bus.auto_mode = 1'b0;
        tick();
        bus.auto_mode = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.din_valid = 1'b0;
        bus.auto_mode = 1'b0;
        tick();
        chk("abort_outp", 32'(bus.outp), 32'h1F);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_fv", 32'(bus.frame_valid), 32'd0);
        bus.sel       = 5'd5;
        bus.din_valid = 1'b1;
        tick();
        chk("abort_direct", 32'(bus.outp), 32'h3F);
        chk("abort_direct_fv", 32'(bus.frame_valid), 32'd0);
        bus.din_valid = 1'b0;

        // Parity bit check (or parity_err tied low)
        send_frame(29'h0000001F, 1'b0);
        if (PAR) begin
            chk("par_wait_busy", 32'(bus.busy), 32'd1);
            bus.din       = 1'b1;
            bus.din_valid = 1'b1;
            tick();
            chk("par_ok_pe", 32'(bus.parity_err), 32'd0);
            chk("par_ok_fv", 32'(bus.frame_valid), 32'd1);
            chk("par_ok_outp", 32'(bus.outp), 32'h1F);
            bus.din_valid = 1'b0;
            send_frame(29'h0000001F, 1'b0);
            bus.din       = 1'b0;
            bus.din_valid = 1'b1;
            tick();
            chk("par_bad_pe", 32'(bus.parity_err), 32'd1);
            chk("par_bad_fv", 32'(bus.frame_valid), 32'd1);
            bus.din_valid = 1'b0;
            tick();
            chk("par_pe_drop", 32'(bus.parity_err), 32'd0);
        end else begin
            chk("nopar_pe", 32'(bus.parity_err), 32'd0);
            chk("nopar_fv", 32'(bus.frame_valid), 32'd1);
            tick();
            chk("nopar_fv_drop", 32'(bus.frame_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
